// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the MEM stage. It accepts one load or store per
//   valid/ready handshake, performs the byte-lane write or the synchronous word
//   read on an internal word-organised array, and returns a one-cycle response.
//   Load data comes back already sized and sign- or zero-extended (RV32 funct3).
//
//   Sequence: IDLE -> ACCESS -> RESP. A new request may be accepted in RESP,
//   so back-to-back throughput is one request every two cycles.
//
// Parameters
//   ADDR_W     byte-address width decoded; the array holds 2**(ADDR_W-2) words
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active-low
//   req_valid  in   request present
//   req_ready  out  responder can accept (IDLE or RESP, and not in reset)
//   req_we     in   1 = store, 0 = load
//   req_ctrl   in   funct3 (B/H/W/BU/HU); 011/110/111 are treated as W
//   req_addr   in   byte address; bits above ADDR_W-1 are ignored (aliasing)
//   req_wdata  in   store data, right-aligned
//   rsp_valid  out  one-cycle response pulse for the oldest accepted request
//   rsp_rdata  out  formatted load data; 0 for stores and faulted accesses
//   rsp_err    out  access faulted (meaningful only with rsp_valid)
//   busy       out  request in flight (state != IDLE)
//
// Configuration macro
//   MISALIGN_TRAP_EN  defined: a misaligned H/W access does not touch the
//                     array and responds with rsp_err=1, rsp_rdata=0.
//                     undefined: misaligned low address bits are forced to
//                     alignment and rsp_err is tied to 0.

module dmem_responder #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [2:0]          ctrl_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdword_q;
  logic [31:0]         mem [WORDS];
  logic                accept;
  logic                wr_block;
  logic [ADDR_W-1:0]   addr_in;
  logic [3:0]          lane_en_w;
  logic [31:0]         wdata_rep;
  logic                unused_addr_hi;

  // Access size from funct3: 00 byte, 01 half, 10 word. ctrl[1] set covers
  // W as well as the reserved encodings 011/110/111, which decode as W.
  function automatic logic [1:0] size_of(input logic [2:0] ctrl);
    return ctrl[1] ? 2'b10 : {1'b0, ctrl[0]};
  endfunction

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0]        sz);
    logic [ADDR_W-1:0] r;
    r = a;
    if (sz == 2'b01)      r[0]   = 1'b0;
    else if (sz == 2'b10) r[1:0] = 2'b00;
    return r;
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] lo, input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is copied onto every lane so the byte-enable alone picks the target.
  function automatic logic [31:0] replicate(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] word,
                                           input logic [1:0]  lo,
                                           input logic [2:0]  ctrl);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (ctrl)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h000000, sh[7:0]};
      3'b101:  return {16'h0000, sh[15:0]};
      default: return word;
    endcase
  endfunction

  assign accept         = req_valid && req_ready;
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] sz);
    return ((sz == 2'b01) && lo[0]) || ((sz == 2'b10) && (lo != 2'b00));
  endfunction

  // Raw address is kept; a faulted access never reaches the array.
  assign addr_in  = req_addr[ADDR_W-1:0];
  assign wr_block = err_q;
  assign rsp_err  = (state_q == RESP) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned(req_addr[1:0], size_of(req_ctrl));
    end
  end
`else
  assign addr_in  = align_addr(req_addr[ADDR_W-1:0], size_of(req_ctrl));
  assign wr_block = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  // ---- Stage: request capture (edge E0) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) we_q <= req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ctrl_q  <= req_ctrl;
      addr_q  <= addr_in;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- Stage: array access (edge E1) ----
  // A reset during ACCESS forces the state to IDLE asynchronously, so an
  // aborted store never sees state_q==ACCESS at the following edge.
  assign lane_en_w = lane_en(addr_q[1:0], size_of(ctrl_q));
  assign wdata_rep = replicate(wdata_q, size_of(ctrl_q));

  always_ff @(posedge clk) begin
    if (state_q == ACCESS) begin
      if (we_q && !wr_block) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_en_w[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
      rdword_q <= mem[addr_q[ADDR_W-1:2]];
    end
  end

  // ---- Stage: response (cycle after E1) ----
  always_comb begin
    req_ready = rst_n && ((state_q == IDLE) || (state_q == RESP));
    busy      = (state_q != IDLE);
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    if (state_q == RESP) begin
      rsp_valid = 1'b1;
      if (!we_q && !wr_block) rsp_rdata = load_fmt(rdword_q, addr_q[1:0], ctrl_q);
    end
  end

endmodule
